// File: rtl/arf_commit_scheduler_if.sv
// Commit-to-ARF bus: two commit lanes, ARF write ports, forwarding lookup.
// Master drives commits/lookups; slave is the scheduler.
interface arf_commit_scheduler_if #(
    parameter int AR_SIZE = 6
);
    logic               cm_valid0;
    logic [AR_SIZE-1:0] cm_addr0;
    logic [31:0]        cm_data0;
    logic               cm_valid1;
    logic [AR_SIZE-1:0] cm_addr1;
    logic [31:0]        cm_data1;
    logic               cm_ready;
    logic               arf_hold;
    logic [AR_SIZE-1:0] write_addr1;
    logic [31:0]        write_data1;
    logic [AR_SIZE-1:0] write_addr2;
    logic [31:0]        write_data2;
    logic               write_en;
    logic [AR_SIZE-1:0] fwd_addr;
    logic               fwd_hit;
    logic [31:0]        fwd_data;
    logic               idle;

    modport master (
        output cm_valid0, cm_addr0, cm_data0,
        output cm_valid1, cm_addr1, cm_data1,
        output arf_hold, fwd_addr,
        input  cm_ready, write_addr1, write_data1,
        input  write_addr2, write_data2, write_en,
        input  fwd_hit, fwd_data, idle
    );

    modport slave (
        input  cm_valid0, cm_addr0, cm_data0,
        input  cm_valid1, cm_addr1, cm_data1,
        input  arf_hold, fwd_addr,
        output cm_ready, write_addr1, write_data1,
        output write_addr2, write_data2, write_en,
        output fwd_hit, fwd_data, idle
    );
endinterface

// File: rtl/arf_commit_scheduler.sv
// ARF commit scheduler: buffers up to two in-order commits per cycle and
// drains two per cycle onto the ARF ports, coalescing same-register pairs.
module arf_commit_scheduler #(
    parameter int AR_SIZE = 6,
    parameter int DEPTH   = 8,
    parameter int PTR_W   = 3
) (
    input logic               clk,
    input logic               rst,
    arf_commit_scheduler_if.slave bus
);
    localparam logic [PTR_W:0] LIMIT = (PTR_W+1)'(DEPTH - 2);

    logic [AR_SIZE-1:0] r_mem_addr [DEPTH];
    logic [31:0]        r_mem_data [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W:0]     r_count;
    logic               r_wen;
    logic [AR_SIZE-1:0] r_wa1;
    logic [AR_SIZE-1:0] r_wa2;
    logic [31:0]        r_wd1;
    logic [31:0]        r_wd2;

    logic               w_ready;
    logic               w_st0;
    logic               w_st1;
    logic [PTR_W-1:0]   w_tail1;
    logic [PTR_W-1:0]   w_head1;
    logic [PTR_W:0]     w_nacc;
    logic [PTR_W:0]     w_npop;
    logic               w_wen;
    logic [AR_SIZE-1:0] w_wa1;
    logic [AR_SIZE-1:0] w_wa2;
    logic [31:0]        w_wd1;
    logic [31:0]        w_wd2;
    logic               w_hit;
    logic [31:0]        w_fdata;

    // x0 commits are handshaked but never occupy a slot
    assign w_ready = !rst && (r_count <= LIMIT);
    assign w_st0   = w_ready && bus.cm_valid0 && (bus.cm_addr0 != '0);
    assign w_st1   = w_ready && bus.cm_valid1 && (bus.cm_addr1 != '0);
    assign w_tail1 = r_tail + PTR_W'(w_st0);
    assign w_head1 = r_head + PTR_W'(1);
    assign w_nacc  = (PTR_W+1)'(w_st0) + (PTR_W+1)'(w_st1);

    // Drain selection from the start-of-cycle occupancy
    always_comb begin
        w_npop = '0;
        w_wen  = 1'b0;
        w_wa1  = '0;
        w_wa2  = '0;
        w_wd1  = r_wd1;
        w_wd2  = r_wd2;
        if (!bus.arf_hold) begin
            if (r_count >= (PTR_W+1)'(2)) begin
                w_npop = (PTR_W+1)'(2);
                w_wen  = 1'b1;
                w_wa2  = r_mem_addr[w_head1];
                w_wd2  = r_mem_data[w_head1];
                if (r_mem_addr[r_head] != r_mem_addr[w_head1]) begin
                    w_wa1 = r_mem_addr[r_head];
                    w_wd1 = r_mem_data[r_head];
                end
            end else if (r_count == (PTR_W+1)'(1)) begin
                w_npop = (PTR_W+1)'(1);
                w_wen  = 1'b1;
                w_wa1  = r_mem_addr[r_head];
                w_wd1  = r_mem_data[r_head];
            end
        end
    end

    // Pointers, occupancy and registered ARF write ports
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_wen   <= 1'b0;
            r_wa1   <= '0;
            r_wa2   <= '0;
            r_wd1   <= '0;
            r_wd2   <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_npop);
            r_tail  <= r_tail + PTR_W'(w_nacc);
            r_count <= r_count + w_nacc - w_npop;
            r_wen   <= w_wen;
            r_wa1   <= w_wa1;
            r_wa2   <= w_wa2;
            r_wd1   <= w_wd1;
            r_wd2   <= w_wd2;
        end
    end

    // Storage write; lane 0 lands first so lane 1 is always younger
    always_ff @(posedge clk) begin
        if (w_st0) begin
            r_mem_addr[r_tail] <= bus.cm_addr0;
            r_mem_data[r_tail] <= bus.cm_data0;
        end
        if (w_st1) begin
            r_mem_addr[w_tail1] <= bus.cm_addr1;
            r_mem_data[w_tail1] <= bus.cm_data1;
        end
    end

    // Lookup over queued entries, later (younger) matches override earlier
    always_comb begin
        w_hit   = 1'b0;
        w_fdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PTR_W+1)'(i) < r_count) && (bus.fwd_addr != '0) &&
                (r_mem_addr[r_head + PTR_W'(i)] == bus.fwd_addr)) begin
                w_hit   = 1'b1;
                w_fdata = r_mem_data[r_head + PTR_W'(i)];
            end
        end
    end

    assign bus.cm_ready    = w_ready;
    assign bus.write_en    = r_wen;
    assign bus.write_addr1 = r_wa1;
    assign bus.write_addr2 = r_wa2;
    assign bus.write_data1 = r_wd1;
    assign bus.write_data2 = r_wd2;
    assign bus.fwd_hit     = w_hit;
    assign bus.fwd_data    = w_fdata;
    assign bus.idle        = (r_count == '0) && !r_wen;
endmodule

// File: tb/tb_arf_commit_scheduler.sv
// Directed + random bench for arf_commit_scheduler with a queue model
// of the FIFO and a scoreboard of expected ARF port values.
module tb_arf_commit_scheduler;
    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } ent_t;

    typedef struct packed {
        logic        wen;
        logic [5:0]  a1;
        logic [31:0] d1;
        logic        c1;
        logic [5:0]  a2;
        logic [31:0] d2;
        logic        c2;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t mq[$];
    exp_t exp_q[$];
    logic m_ready;
    logic p_wen = 1'b0;

    arf_commit_scheduler_if #(.AR_SIZE(6)) u_if();

    arf_commit_scheduler #(.AR_SIZE(6), .DEPTH(8), .PTR_W(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [5:0] a0,
                         input logic [31:0] d0, input logic v1,
                         input logic [5:0] a1, input logic [31:0] d1);
        u_if.cm_valid0 = v0;
        u_if.cm_addr0  = a0;
        u_if.cm_data0  = d0;
        u_if.cm_valid1 = v1;
        u_if.cm_addr1  = a1;
        u_if.cm_data1  = d1;
    endtask

    // One clock: check combinational outputs, predict, step, compare ports
    task automatic cyc();
        ent_t e0;
        ent_t e1;
        exp_t x;
        logic fh;
        logic [31:0] fd;
        #1;
        m_ready = !rst && (mq.size() <= 6);
        chk("cm_ready", u_if.cm_ready, m_ready);
        chk("idle", u_if.idle, (mq.size() == 0) && !p_wen);
        fh = 1'b0;
        fd = '0;
        foreach (mq[i]) begin
            if (u_if.fwd_addr != 0 && mq[i].a == u_if.fwd_addr) begin
                fh = 1'b1;
                fd = mq[i].d;
            end
        end
        chk("fwd_hit", u_if.fwd_hit, fh);
        chk("fwd_data", u_if.fwd_data, fd);
        x = '0;
        if (rst) begin
            mq.delete();
            x.c1 = 1'b1;
            x.c2 = 1'b1;
        end else begin
            if (!u_if.arf_hold) begin
                if (mq.size() >= 2) begin
                    e0 = mq.pop_front();
                    e1 = mq.pop_front();
                    x.wen = 1'b1;
                    x.a2 = e1.a;
                    x.d2 = e1.d;
                    x.c2 = 1'b1;
                    if (e0.a != e1.a) begin
                        x.a1 = e0.a;
                        x.d1 = e0.d;
                        x.c1 = 1'b1;
                    end
                end else if (mq.size() == 1) begin
                    e0 = mq.pop_front();
                    x.wen = 1'b1;
                    x.a1 = e0.a;
                    x.d1 = e0.d;
                    x.c1 = 1'b1;
                end
            end
            if (m_ready && u_if.cm_valid0 && u_if.cm_addr0 != 0)
                mq.push_back('{a: u_if.cm_addr0, d: u_if.cm_data0});
            if (m_ready && u_if.cm_valid1 && u_if.cm_addr1 != 0)
                mq.push_back('{a: u_if.cm_addr1, d: u_if.cm_data1});
        end
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        chk("write_en", u_if.write_en, x.wen);
        chk("write_addr1", u_if.write_addr1, x.a1);
        chk("write_addr2", u_if.write_addr2, x.a2);
        if (x.c1) chk("write_data1", u_if.write_data1, x.d1);
        if (x.c2) chk("write_data2", u_if.write_data2, x.d2);
        p_wen = x.wen;
    endtask

    initial begin
        int k;
        rst = 1'b1;
        u_if.arf_hold = 1'b0;
        u_if.fwd_addr = '0;
        drive(1'b1, 6'd5, 32'hDEAD, 1'b0, 6'd0, 32'h0);
        @(posedge clk);
        #1;
        // reset held with a valid commit present
        cyc();
        cyc();
        rst = 1'b0;
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        cyc();
        cyc();
        chk("post_reset_idle", u_if.idle, 1'b1);

        // single commit, 2-cycle latency
        drive(1'b1, 6'd5, 32'h1234, 1'b0, 6'd0, 32'h0);
        cyc();
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        cyc();
        chk("single_wen", u_if.write_en, 1'b1);
        chk("single_data", u_if.write_data1, 32'h1234);
        cyc();
        cyc();

        // same-register coalesce, then x0 drop
        drive(1'b1, 6'd7, 32'hA, 1'b1, 6'd7, 32'hB);
        cyc();
        drive(1'b1, 6'd3, 32'h1, 1'b1, 6'd0, 32'h9);
        cyc();
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        chk("coalesce_a2", u_if.write_addr2, 32'd7);
        chk("coalesce_d2", u_if.write_data2, 32'hB);
        cyc();
        cyc();
        cyc();

        // fill under hold, then drain at 2 per cycle
        u_if.arf_hold = 1'b1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 6'(10 + 2 * k), 32'h100 + k,
                  1'b1, 6'(11 + 2 * k), 32'h200 + k);
            cyc();
            if (m_ready) k++;
        end
        chk("full_ready_low", u_if.cm_ready, 1'b0);
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        u_if.arf_hold = 1'b0;
        for (int c = 0; c < 6; c++) cyc();

        // forwarding of the youngest queued entry
        u_if.arf_hold = 1'b1;
        drive(1'b1, 6'd9, 32'h11, 1'b0, 6'd0, 32'h0);
        cyc();
        drive(1'b1, 6'd9, 32'h22, 1'b0, 6'd0, 32'h0);
        cyc();
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        u_if.fwd_addr = 6'd9;
        cyc();
        u_if.fwd_addr = 6'd4;
        cyc();
        u_if.fwd_addr = 6'd0;
        cyc();

        // reset with entries queued
        drive(1'b1, 6'd20, 32'h55, 1'b1, 6'd21, 32'h66);
        cyc();
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        u_if.arf_hold = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("reset_flush_idle", u_if.idle, 1'b1);
        for (int c = 0; c < 3; c++) cyc();

        // random traffic with collisions, hold and lookups
        for (int c = 0; c < 60; c++) begin
            drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                  $urandom,
                  1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
                  $urandom);
            u_if.arf_hold = ($urandom_range(0, 3) == 0);
            u_if.fwd_addr = 6'($urandom_range(0, 7));
            cyc();
        end
        drive(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0);
        u_if.arf_hold = 1'b0;
        for (int c = 0; c < 8; c++) cyc();
        chk("final_idle", u_if.idle, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
